// File: rtl/rename_map_pkg.sv
// Shared rename types: architectural/physical register ids, rename packets and
// the wrap-bit free-list pointer with its increment helper.
package rename_defs;
    localparam int RV_NUM_REGS  = 32;
    localparam int PRF_NUM_ENTS = 64;
    localparam int NUM_SOURCES  = 2;
    localparam int FL_DEPTH     = PRF_NUM_ENTS - RV_NUM_REGS + 1;
    localparam int PRF_W        = $clog2(PRF_NUM_ENTS);
    localparam int GPR_W        = $clog2(RV_NUM_REGS);
    localparam int FL_IDX_W     = $clog2(FL_DEPTH);
    localparam int FL_CNT_W     = FL_IDX_W + 1;

    typedef logic [PRF_W-1:0] t_prf_id;
    typedef logic [GPR_W-1:0] t_gpr_id;

    typedef enum logic [1:0] {OP_NONE = 2'd0, OP_REG = 2'd1, OP_IMM = 2'd2} t_optype;

    typedef struct packed {
        t_optype optype;
        t_gpr_id opreg;
    } t_dst;

    typedef struct packed {
        t_dst                          dst;
        t_gpr_id [NUM_SOURCES-1:0]     src;
    } t_uinstr;

    typedef struct packed {
        t_prf_id [NUM_SOURCES-1:0] psrc;
        t_prf_id                   pdst;
        t_prf_id                   pdst_old;
    } t_rename_pkt;

    typedef struct packed {
        logic    valid;
        t_gpr_id gpr;
        t_prf_id prfid;
    } t_rat_restore_pkt;

    typedef struct packed {
        logic valid;
    } t_nuke_pkt;

    typedef struct packed {
        logic                wrap;
        logic [FL_IDX_W-1:0] idx;
    } t_fl_ptr;

    // FL_DEPTH is not a power of two, so the index wraps explicitly.
    function automatic t_fl_ptr fl_ptr_inc(input t_fl_ptr p);
        t_fl_ptr r;
        if (p.idx == FL_IDX_W'(FL_DEPTH - 1)) begin
            r.idx  = '0;
            r.wrap = ~p.wrap;
        end else begin
            r.idx  = p.idx + 1'b1;
            r.wrap = p.wrap;
        end
        return r;
    endfunction
endpackage

// File: rtl/rename_map_freelist.sv
// Physical register free list: FIFO with one pop and two ordered push ports
// (push0 lands at tail, push1 behind it when both fire).
module prf_freelist
    import rename_defs::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                pop_i,
    output t_prf_id             head_o,
    output logic                empty_o,
    input  logic                push0_i,
    input  t_prf_id             push0_id_i,
    input  logic                push1_i,
    input  t_prf_id             push1_id_i,
    output logic [FL_CNT_W-1:0] count_o
);
    t_prf_id             mem_q [FL_DEPTH];
    t_fl_ptr             head_q, head_d, tail_q, tail_d, tail_p1, tail_p2;
    logic [FL_IDX_W-1:0] slot1;
    logic                full;

    assign empty_o = (head_q == tail_q);
    assign full    = (head_q.idx == tail_q.idx) && (head_q.wrap != tail_q.wrap);
    assign head_o  = mem_q[head_q.idx];

    always_comb begin
        tail_p1 = fl_ptr_inc(tail_q);
        tail_p2 = fl_ptr_inc(tail_p1);
        tail_d  = tail_q;
        if (push0_i && push1_i)      tail_d = tail_p2;
        else if (push0_i || push1_i) tail_d = tail_p1;
        slot1   = push0_i ? tail_p1.idx : tail_q.idx;
        head_d  = pop_i ? fl_ptr_inc(head_q) : head_q;
    end

    always_comb begin
        if (head_q.wrap == tail_q.wrap)
            count_o = FL_CNT_W'(tail_q.idx) - FL_CNT_W'(head_q.idx);
        else
            count_o = FL_CNT_W'(FL_DEPTH) + FL_CNT_W'(tail_q.idx) - FL_CNT_W'(head_q.idx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FL_DEPTH; i++)
                mem_q[i] <= (i < PRF_NUM_ENTS - RV_NUM_REGS) ? t_prf_id'(RV_NUM_REGS + i) : '0;
            head_q <= '0;
            tail_q <= '{wrap: 1'b0, idx: FL_IDX_W'(PRF_NUM_ENTS - RV_NUM_REGS)};
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            if (push0_i) mem_q[tail_q.idx] <= push0_id_i;
            if (push1_i) mem_q[slot1]      <= push1_id_i;
        end
    end

`ifndef SYNTHESIS
    logic [PRF_NUM_ENTS-1:0] in_use_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PRF_NUM_ENTS; i++) in_use_q[i] <= (i < RV_NUM_REGS);
        end else begin
            if (pop_i)   in_use_q[head_o]     <= 1'b1;
            if (push0_i) in_use_q[push0_id_i] <= 1'b0;
            if (push1_i) in_use_q[push1_id_i] <= 1'b0;
        end
    end

    a_pop_empty: assert property (@(posedge clk) disable iff (reset) !(pop_i && empty_o));
    a_push_full: assert property (@(posedge clk) disable iff (reset)
        !((push0_i || push1_i) && full && !pop_i));
    a_overflow:  assert property (@(posedge clk) disable iff (reset)
        (int'(count_o) + int'(push0_i) + int'(push1_i)) <= (FL_DEPTH + int'(pop_i)));
    a_dfree0:    assert property (@(posedge clk) disable iff (reset) !(push0_i && !in_use_q[push0_id_i]));
    a_dfree1:    assert property (@(posedge clk) disable iff (reset) !(push1_i && !in_use_q[push1_id_i]));
    a_dfree01:   assert property (@(posedge clk) disable iff (reset)
        !(push0_i && push1_i && (push0_id_i == push1_id_i)));
    a_prf0:      assert property (@(posedge clk) disable iff (reset)
        !((push0_i && push0_id_i == '0) || (push1_i && push1_id_i == '0)));
`endif
endmodule

// File: rtl/rename_map.sv
// Register alias table with free list; renames one uop per cycle and walks
// restore packets back in after a nuke.
module rename_map
    import rename_defs::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                rename_valid_ra0,
    input  t_uinstr             uinstr_ra0,
    output logic                rename_ready_ra0,
    output t_rename_pkt         rename_ra0,
    input  logic                reclaim_prf_rb1,
    input  t_prf_id             reclaim_prf_id_rb1,
    input  t_rat_restore_pkt    rat_restore_pkt_rbx,
    input  t_nuke_pkt           nuke_rb1,
    input  logic                resume_fetch_rbx,
    output logic [FL_CNT_W-1:0] fl_count
);
    t_prf_id rat_q [RV_NUM_REGS];
    logic    restore_mode_q, restore_mode_d;
    logic    fl_empty, dst_wr, rst_wr;
    t_prf_id fl_head, rst_old;

    assign rename_ready_ra0 = ~fl_empty & ~restore_mode_q & ~nuke_rb1.valid;
    assign dst_wr = rename_valid_ra0 & rename_ready_ra0 &
                    (uinstr_ra0.dst.optype == OP_REG) & (uinstr_ra0.dst.opreg != '0);
    assign rst_wr  = rat_restore_pkt_rbx.valid & (rat_restore_pkt_rbx.gpr != '0);
    // The RAT write lands at the edge, so a following packet to the same gpr
    // already reads the previous packet's prfid and frees it.
    assign rst_old = rat_q[rat_restore_pkt_rbx.gpr];

    always_comb begin
        rename_ra0 = '0;
        for (int i = 0; i < NUM_SOURCES; i++)
            rename_ra0.psrc[i] = rat_q[uinstr_ra0.src[i]];
        if (dst_wr) begin
            rename_ra0.pdst     = fl_head;
            rename_ra0.pdst_old = rat_q[uinstr_ra0.dst.opreg];
        end
    end

    always_comb begin
        restore_mode_d = restore_mode_q;
        if (nuke_rb1.valid)        restore_mode_d = 1'b1;
        else if (resume_fetch_rbx) restore_mode_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RV_NUM_REGS; i++) rat_q[i] <= t_prf_id'(i);
            restore_mode_q <= 1'b0;
        end else begin
            restore_mode_q <= restore_mode_d;
            if (rst_wr)      rat_q[rat_restore_pkt_rbx.gpr] <= rat_restore_pkt_rbx.prfid;
            else if (dst_wr) rat_q[uinstr_ra0.dst.opreg]    <= fl_head;
        end
    end

    prf_freelist u_fl (
        .clk        (clk),
        .reset      (reset),
        .pop_i      (dst_wr),
        .head_o     (fl_head),
        .empty_o    (fl_empty),
        .push0_i    (reclaim_prf_rb1),
        .push0_id_i (reclaim_prf_id_rb1),
        .push1_i    (rst_wr),
        .push1_id_i (rst_old),
        .count_o    (fl_count)
    );

`ifndef SYNTHESIS
    a_restore_mode: assert property (@(posedge clk) disable iff (reset)
        !(rat_restore_pkt_rbx.valid && !restore_mode_q));
    a_rename_mode:  assert property (@(posedge clk) disable iff (reset)
        !(rename_valid_ra0 && restore_mode_q));
`endif
endmodule

// File: tb/tb_rename_map.sv
// Rename map bench: queue/array reference model compared every cycle, plus
// directed scenarios with literal expectations and a randomized rename/retire/nuke walk.
module tb_rename_map;
    import rename_defs::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                rename_valid_ra0;
    t_uinstr             uinstr_ra0;
    logic                rename_ready_ra0;
    t_rename_pkt         rename_ra0;
    logic                reclaim_prf_rb1;
    t_prf_id             reclaim_prf_id_rb1;
    t_rat_restore_pkt    rat_restore_pkt_rbx;
    t_nuke_pkt           nuke_rb1;
    logic                resume_fetch_rbx;
    logic [FL_CNT_W-1:0] fl_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rename_map dut (
        .clk                 (clk),
        .reset               (reset),
        .rename_valid_ra0    (rename_valid_ra0),
        .uinstr_ra0          (uinstr_ra0),
        .rename_ready_ra0    (rename_ready_ra0),
        .rename_ra0          (rename_ra0),
        .reclaim_prf_rb1     (reclaim_prf_rb1),
        .reclaim_prf_id_rb1  (reclaim_prf_id_rb1),
        .rat_restore_pkt_rbx (rat_restore_pkt_rbx),
        .nuke_rb1            (nuke_rb1),
        .resume_fetch_rbx    (resume_fetch_rbx),
        .fl_count            (fl_count)
    );

    // ---------------- reference model ----------------
    int m_rat [RV_NUM_REGS];
    int m_free [$];
    bit m_mode;
    bit m_live = 1'b0;

    function automatic void m_reset();
        for (int i = 0; i < RV_NUM_REGS; i++) m_rat[i] = i;
        m_free.delete();
        for (int p = RV_NUM_REGS; p < PRF_NUM_ENTS; p++) m_free.push_back(p);
        m_mode = 1'b0;
        m_live = 1'b1;
    endfunction

    function automatic bit m_ready();
        return (m_free.size() != 0) && !m_mode && !nuke_rb1.valid;
    endfunction

    function automatic bit m_writes();
        return rename_valid_ra0 && m_ready() && (uinstr_ra0.dst.optype == OP_REG) &&
               (uinstr_ra0.dst.opreg != 0);
    endfunction

    always @(posedge clk) begin
        int g;
        if (reset) m_reset();
        else if (m_live) begin
            if (m_writes()) m_rat[uinstr_ra0.dst.opreg] = m_free.pop_front();
            if (reclaim_prf_rb1) m_free.push_back(int'(reclaim_prf_id_rb1));
            g = int'(rat_restore_pkt_rbx.gpr);
            if (rat_restore_pkt_rbx.valid && g != 0) begin
                m_free.push_back(m_rat[g]);
                m_rat[g] = int'(rat_restore_pkt_rbx.prfid);
            end
            if (nuke_rb1.valid)        m_mode = 1'b1;
            else if (resume_fetch_rbx) m_mode = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        total++;
        if (act !== 32'(exp)) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // every-cycle comparison against the model
    always @(negedge clk) begin
        int exp_pd, exp_po;
        if (m_live && !reset) begin
            chk("ready", 32'(rename_ready_ra0), int'(m_ready()));
            chk("fl_count", 32'(fl_count), m_free.size());
            for (int i = 0; i < NUM_SOURCES; i++)
                chk("psrc", 32'(rename_ra0.psrc[i]), m_rat[uinstr_ra0.src[i]]);
            exp_pd = 0;
            exp_po = 0;
            if (m_writes()) begin
                exp_pd = m_free[0];
                exp_po = m_rat[uinstr_ra0.dst.opreg];
            end
            chk("pdst", 32'(rename_ra0.pdst), exp_pd);
            chk("pdst_old", 32'(rename_ra0.pdst_old), exp_po);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        rename_valid_ra0    = 1'b0;
        uinstr_ra0          = '0;
        reclaim_prf_rb1     = 1'b0;
        reclaim_prf_id_rb1  = '0;
        rat_restore_pkt_rbx = '0;
        nuke_rb1            = '0;
        resume_fetch_rbx    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_ren(input bit v, input t_optype ot, input int d, input int s0, input int s1);
        rename_valid_ra0      = v;
        uinstr_ra0.dst.optype = ot;
        uinstr_ra0.dst.opreg  = t_gpr_id'(d);
        uinstr_ra0.src[0]     = t_gpr_id'(s0);
        uinstr_ra0.src[1]     = t_gpr_id'(s1);
    endtask

    task automatic set_rst(input int g, input int p);
        rat_restore_pkt_rbx.valid = 1'b1;
        rat_restore_pkt_rbx.gpr   = t_gpr_id'(g);
        rat_restore_pkt_rbx.prfid = t_prf_id'(p);
    endtask

    int rob_dst [$];
    int rob_po  [$];

    initial begin
        int ph, d, junk;
        t_optype ot;
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;

        // first rename after reset
        set_ren(1, OP_REG, 5, 6, 0);
        #2;
        chk("r27_ready", 32'(rename_ready_ra0), 1);
        chk("r27_count0", 32'(fl_count), 32);
        chk("r27_pdst", 32'(rename_ra0.pdst), 32);
        chk("r27_pdst_old", 32'(rename_ra0.pdst_old), 5);
        chk("r27_psrc", 32'(rename_ra0.psrc[0]), 6);
        tick();
        set_ren(0, OP_REG, 0, 5, 0);
        #2;
        chk("r27_rat5", 32'(rename_ra0.psrc[0]), 32);
        chk("r27_count1", 32'(fl_count), 31);

        // non-writing renames
        tick();
        set_ren(1, OP_REG, 0, 1, 2);
        #2;
        chk("r31_x0_pdst", 32'(rename_ra0.pdst), 0);
        chk("r31_x0_old", 32'(rename_ra0.pdst_old), 0);
        tick();
        set_ren(1, OP_IMM, 7, 0, 0);
        #2;
        chk("r31_imm_pdst", 32'(rename_ra0.pdst), 0);
        chk("r31_imm_old", 32'(rename_ra0.pdst_old), 0);
        tick();
        idle_inputs();
        #2;
        chk("r31_count", 32'(fl_count), 31);

        // exhaust the free list, then refill with one reclaim
        do_reset();
        for (int k = 0; k < 32; k++) begin
            set_ren(1, OP_REG, 1, 0, 0);
            tick();
        end
        idle_inputs();
        #2;
        chk("r28_empty_ready", 32'(rename_ready_ra0), 0);
        chk("r28_empty_count", 32'(fl_count), 0);
        set_ren(1, OP_REG, 2, 0, 0);
        reclaim_prf_rb1    = 1'b1;
        reclaim_prf_id_rb1 = t_prf_id'(1);
        #2;
        chk("r28_same_cycle_ready", 32'(rename_ready_ra0), 0);
        tick();
        reclaim_prf_rb1 = 1'b0;
        #2;
        chk("r28_ready", 32'(rename_ready_ra0), 1);
        chk("r28_pdst", 32'(rename_ra0.pdst), 1);
        chk("r28_pdst_old", 32'(rename_ra0.pdst_old), 2);
        tick();
        idle_inputs();

        // chained restore of the same gpr
        do_reset();
        set_ren(1, OP_REG, 3, 0, 0);
        #2;
        chk("r29_pdst_a", 32'(rename_ra0.pdst), 32);
        tick();
        #2;
        chk("r29_pdst_b", 32'(rename_ra0.pdst), 33);
        chk("r29_old_b", 32'(rename_ra0.pdst_old), 32);
        tick();
        idle_inputs();
        nuke_rb1.valid = 1'b1;
        tick();
        idle_inputs();
        set_rst(3, 32);
        tick();
        set_rst(3, 3);
        tick();
        idle_inputs();
        resume_fetch_rbx = 1'b1;
        #2;
        chk("r29_count", 32'(fl_count), 32);
        chk("r29_mode_ready", 32'(rename_ready_ra0), 0);
        tick();
        idle_inputs();
        set_ren(0, OP_REG, 0, 3, 0);
        #2;
        chk("r29_rat3", 32'(rename_ra0.psrc[0]), 3);
        chk("r29_ready", 32'(rename_ready_ra0), 1);

        // simultaneous reclaim and restore push
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            set_ren(1, OP_REG, k, 0, 0);
            tick();
        end
        set_ren(1, OP_REG, 9, 0, 0);
        #2;
        chk("r30_pdst", 32'(rename_ra0.pdst), 42);
        chk("r30_old", 32'(rename_ra0.pdst_old), 40);
        tick();
        idle_inputs();
        #2;
        chk("r30_count_pre", 32'(fl_count), 21);
        nuke_rb1.valid = 1'b1;
        tick();
        idle_inputs();
        reclaim_prf_rb1    = 1'b1;
        reclaim_prf_id_rb1 = t_prf_id'(40);
        set_rst(10, 10);
        tick();
        idle_inputs();
        #2;
        chk("r30_count_post", 32'(fl_count), 23);
        resume_fetch_rbx = 1'b1;
        tick();
        idle_inputs();
        set_ren(0, OP_REG, 0, 10, 9);
        #2;
        chk("r30_rat10", 32'(rename_ra0.psrc[0]), 10);
        chk("r30_rat9", 32'(rename_ra0.psrc[1]), 42);

        // reset in the middle of a walk
        do_reset();
        set_ren(1, OP_REG, 4, 0, 0);
        tick();
        idle_inputs();
        nuke_rb1.valid = 1'b1;
        tick();
        idle_inputs();
        set_rst(4, 4);
        tick();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_ren(0, OP_REG, 0, 4, 31);
        #2;
        chk("r32_count", 32'(fl_count), 32);
        chk("r32_ready", 32'(rename_ready_ra0), 1);
        chk("r32_rat4", 32'(rename_ra0.psrc[0]), 4);
        chk("r32_rat31", 32'(rename_ra0.psrc[1]), 31);

        // randomized rename / retire / nuke+walk
        do_reset();
        ph = 0;
        for (int c = 0; c < 4000; c++) begin
            idle_inputs();
            if (rob_po.size() > 0 && $urandom_range(0, 3) == 0) begin
                reclaim_prf_rb1    = 1'b1;
                reclaim_prf_id_rb1 = t_prf_id'(rob_po.pop_front());
                junk = rob_dst.pop_front();
            end
            if (ph == 0) begin
                if ($urandom_range(0, 60) == 0) begin
                    nuke_rb1.valid = 1'b1;
                    ph = 1;
                end else if ($urandom_range(0, 3) != 0) begin
                    d  = int'($urandom_range(0, RV_NUM_REGS - 1));
                    ot = ($urandom_range(0, 7) == 0) ? OP_IMM : OP_REG;
                    set_ren(1, ot, d, int'($urandom_range(0, RV_NUM_REGS - 1)),
                            int'($urandom_range(0, RV_NUM_REGS - 1)));
                    if (m_ready() && ot == OP_REG && d != 0) begin
                        rob_dst.push_back(d);
                        rob_po.push_back(m_rat[d]);
                    end
                end
            end else if (rob_dst.size() > 0) begin
                if ($urandom_range(0, 2) != 0) set_rst(rob_dst.pop_back(), rob_po.pop_back());
            end else begin
                resume_fetch_rbx = 1'b1;
                ph = 0;
            end
            tick();
        end
        idle_inputs();
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rename_map.md
RENAME_MAP -- requirements
Module: rename_map

Interface
REQ-001 SHALL have ports: clk in 1 core clock; reset in 1 synchronous active-high reset.
REQ-002 SHALL have ports: rename_valid_ra0 in 1 rename request; uinstr_ra0 in t_uinstr (dst.optype, dst.opreg, src operand addrs); rename_ready_ra0 out 1 rename may proceed this cycle.
REQ-003 SHALL have port rename_ra0 out t_rename_pkt (psrc[NUM_SOURCES], pdst, pdst_old), combinational in ra0.
REQ-004 SHALL have ports: reclaim_prf_rb1 in 1; reclaim_prf_id_rb1 in t_prf_id (retired instr's old PRF).
REQ-005 SHALL have ports: rat_restore_pkt_rbx in t_rat_restore_pkt (valid, gpr, prfid); nuke_rb1 in t_nuke_pkt; resume_fetch_rbx in 1.
REQ-006 SHALL have port fl_count out log2(FL_DEPTH)+1 free-list occupancy.

Function
REQ-007 SHALL hold RAT[RV_NUM_REGS] of t_prf_id; x0 SHALL always read PRF 0 and never be written.
REQ-008 SHALL give psrc[i] = RAT[src addr i] (current, pre-update value) for every source.
REQ-009 SHALL treat rename as dst-writing when rename_valid_ra0 & rename_ready_ra0 & dst.optype==OP_REG & dst.opreg!=0.
REQ-010 On dst-writing rename: pdst = free-list head entry, pdst_old = RAT[dst]; next cycle RAT[dst]=pdst and the head is popped.
REQ-011 On non-writing rename: pdst=0, pdst_old=0; no RAT or free-list change.
REQ-012 rename_ready_ra0 SHALL be ~fl_empty & ~restore_mode & ~nuke_rb1.valid.
REQ-013 Free list SHALL be a FIFO of depth FL_DEPTH = PRF_NUM_ENTS-RV_NUM_REGS+1 with wrap-bit head/tail pointers; empty = pointers equal; full = idx equal, wrap differs.
REQ-014 reclaim_prf_rb1 SHALL push reclaim_prf_id_rb1 at the tail in the next cycle.
REQ-015 restore_mode SHALL set the cycle after nuke_rb1.valid and clear the cycle after resume_fetch_rbx; restore_mode is 0 out of reset.
REQ-016 Each rat_restore_pkt_rbx.valid & gpr!=0 cycle SHALL push current RAT[gpr] to the free list and set RAT[gpr]=prfid next cycle.
REQ-017 Back-to-back restore packets to the same gpr SHALL chain: the second frees the first's prfid (forward the pending RAT write).
REQ-018 Simultaneous reclaim and restore push: reclaim lands at tail, restore at tail+1; tail advances by 2.
REQ-019 Simultaneous pop (rename) and push SHALL both be honoured; push to an empty list is not visible to rename until the next cycle.
REQ-020 Restore packets outside restore_mode and renames while restore_mode SHALL never occur (asserted, not handled).
REQ-021 fl_count SHALL equal tail-head (wrap-aware) registered value.

Reset
REQ-022 On reset: RAT[i]=i for all i; free list holds PRF ids RV_NUM_REGS..PRF_NUM_ENTS-1 in ascending order at head..; fl_count=PRF_NUM_ENTS-RV_NUM_REGS; restore_mode=0.
REQ-023 Reset mid-walk SHALL abandon the walk; reset state applies next cycle irrespective of inputs.

Structure
REQ-024 RV_NUM_REGS, PRF_NUM_ENTS, t_prf_id, t_rename_pkt, t_rat_restore_pkt SHALL live in rename_defs; FL_DEPTH derived there.
REQ-025 The free list SHALL be a sub-module prf_freelist (1 pop, 2 push ports, count out).
REQ-026 SIMULATION-only assertions: push when full, pop when empty, double free (per-PRF in-use bit vector), PRF 0 pushed.

Verification
REQ-027 Reset then rename x5<-x6: pdst=32, pdst_old=5, psrc=6; next cycle RAT[5]=32, fl_count=31.
REQ-028 Rename 32 writers to x1 with no reclaim -> rename_ready_ra0 drops after 32nd; reclaim PRF 1 -> ready rises next cycle and pdst=1.
REQ-029 Rename x3 twice (pdst 32,33), nuke, restore {x3,32} then {x3,3} -> frees 33 then 32, RAT[3]=3, fl_count=32.
REQ-030 Same cycle reclaim 40 and restore freeing 41 -> tail +2, entries 40 then 41, fl_count +2.
REQ-031 Rename dst x0 and dst optype non-reg -> pdst=0, pdst_old=0, fl_count unchanged.
REQ-032 Assert reset during restore walk -> next cycle RAT identity, fl_count=32, restore_mode=0, ready=1.
